// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared constants and FSM encoding for the pipeline hazard
//               controller and its register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam int REG_INDEX_BIT_WIDTH = 4;
    localparam int NUM_REGS            = 16;
    localparam int PEND_CNT_WIDTH      = 2;
    localparam int STALL_CNT_WIDTH     = 16;

    localparam logic [PEND_CNT_WIDTH-1:0] PEND_CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_WAIT  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register saturating pending-write counters with one
//               increment port, one decrement port, two busy read ports and
//               a sticky over/underflow error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int REG_INDEX_BIT_WIDTH = pipe_hazard_ctrl_pkg::REG_INDEX_BIT_WIDTH,
    parameter int NUM_REGS            = pipe_hazard_ctrl_pkg::NUM_REGS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           inc_en,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] inc_idx,
    input  logic                           dec_en,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_idx,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] rd_idx_a,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] rd_idx_b,
    output logic                           rd_busy_a,
    output logic                           rd_busy_b,
    output logic                           err
);
    import pipe_hazard_ctrl_pkg::*;

    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_err_evt;
    logic                r_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            logic                      w_inc_hit;
            logic                      w_dec_hit;
            logic [PEND_CNT_WIDTH-1:0] r_cnt;

            assign w_inc_hit = inc_en && (inc_idx == REG_INDEX_BIT_WIDTH'(gi));
            assign w_dec_hit = dec_en && (dec_idx == REG_INDEX_BIT_WIDTH'(gi));
            assign w_busy[gi] = |r_cnt;

            // Overflow at max or underflow at zero; a matched inc+dec cancels out.
            assign w_err_evt[gi] = (w_inc_hit && !w_dec_hit && (r_cnt == PEND_CNT_MAX)) ||
                                   (w_dec_hit && !w_inc_hit && (r_cnt == '0));

            // Saturating pending-write counter for this register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (w_inc_hit && !w_dec_hit && (r_cnt != PEND_CNT_MAX)) begin
                    r_cnt <= r_cnt + PEND_CNT_WIDTH'(1);
                end else if (w_dec_hit && !w_inc_hit && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - PEND_CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    // Sticky error: once any entry over/underflows it stays set until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (|w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign rd_busy_a = w_busy[rd_idx_a];
    assign rd_busy_b = w_busy[rd_idx_b];
    assign err       = r_err;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : In-order pipeline hazard controller. Stalls decode on RAW
//               hazards tracked by a register scoreboard and holds fetch
//               while a branch resolves, flushing IF on a taken branch.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_INDEX_BIT_WIDTH = pipe_hazard_ctrl_pkg::REG_INDEX_BIT_WIDTH,
    parameter int NUM_REGS            = pipe_hazard_ctrl_pkg::NUM_REGS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dec_valid,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_rs1,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_rs2,
    input  logic                           dec_use_rs1,
    input  logic                           dec_use_rs2,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_rd,
    input  logic                           dec_wrReg,
    input  logic                           dec_is_br,
    input  logic                           ex_br_resolved,
    input  logic                           ex_take_br,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] wb_rd,
    input  logic                           wb_wrReg,
    output logic                           pc_wrt_en,
    output logic                           IF_wrt_en,
    output logic                           DEC_wrt_en,
    output logic                           EX_wrt_en,
    output logic                           ME_wrt_en,
    output logic                           dec_bubble,
    output logic                           if_flush,
    output logic [1:0]                     state,
    output logic [15:0]                    stall_cycles,
    output logic                           sb_err
);
    import pipe_hazard_ctrl_pkg::*;

    state_t                     r_state;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cycles;

    logic w_busy_rs1;
    logic w_busy_rs2;
    logic w_raw_hazard;
    logic w_issue;
    logic w_sb_inc;

    reg_scoreboard #(
        .REG_INDEX_BIT_WIDTH (REG_INDEX_BIT_WIDTH),
        .NUM_REGS            (NUM_REGS)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .inc_en    (w_sb_inc),
        .inc_idx   (dec_rd),
        .dec_en    (wb_wrReg),
        .dec_idx   (wb_rd),
        .rd_idx_a  (dec_rs1),
        .rd_idx_b  (dec_rs2),
        .rd_busy_a (w_busy_rs1),
        .rd_busy_b (w_busy_rs2),
        .err       (sb_err)
    );

    // A write sitting in WB this cycle still reads as pending (no bypass).
    assign w_raw_hazard = dec_valid & ((dec_use_rs1 & w_busy_rs1) |
                                       (dec_use_rs2 & w_busy_rs2));
    assign w_issue      = dec_valid & ~w_raw_hazard & (r_state == RUN);
    assign w_sb_inc     = w_issue & dec_wrReg;

    // Pipeline enables, bubble and flush decoded from state and hazard.
    always_comb begin
        pc_wrt_en  = 1'b1;
        IF_wrt_en  = 1'b1;
        DEC_wrt_en = 1'b1;
        EX_wrt_en  = 1'b1;
        ME_wrt_en  = 1'b1;
        dec_bubble = 1'b0;
        if_flush   = 1'b0;
        if (reset) begin
            // Everything loads so the pipeline registers clear to NOPs.
            dec_bubble = 1'b1;
            if_flush   = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_raw_hazard) begin
                        pc_wrt_en  = 1'b0;
                        IF_wrt_en  = 1'b0;
                        dec_bubble = 1'b1;
                    end
                end
                BR_WAIT: begin
                    pc_wrt_en  = 1'b0;
                    IF_wrt_en  = 1'b0;
                    dec_bubble = 1'b1;
                end
                REDIRECT: begin
                    dec_bubble = 1'b1;
                    if_flush   = 1'b1;
                end
                default: begin
                    dec_bubble = 1'b1;
                end
            endcase
        end
    end

    // Branch FSM: wait for EX to resolve an issued branch, redirect if taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_issue && dec_is_br) begin
                        r_state <= BR_WAIT;
                    end
                end
                BR_WAIT: begin
                    if (ex_br_resolved) begin
                        r_state <= ex_take_br ? REDIRECT : RUN;
                    end
                end
                REDIRECT: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    // Free-running count of decode bubble cycles, wrapping on overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (dec_bubble) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_WIDTH'(1);
        end
    end

    assign state        = r_state;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_INDEX_BIT_WIDTH, default 4: register-number width.
REQ-002 Parameter NUM_REGS, default 16: scoreboard entries.
REQ-003 clk  in  1  processor clock; the block has one clock.
REQ-004 reset  in  1  reset, synchronous and active-high.
REQ-005 dec_valid  in  1  decode stage holds a real instruction.
REQ-006 dec_rs1, dec_rs2  in  4 each  decode source register numbers.
REQ-007 dec_use_rs1, dec_use_rs2  in  1 each  source actually read.
REQ-008 dec_rd  in  4;  dec_wrReg  in  1  decode destination register and its write enable.
REQ-009 dec_is_br  in  1  decode instruction is a branch or JAL.
REQ-010 ex_br_resolved  in  1;  ex_take_br  in  1  branch in EX resolved this cycle, and its outcome.
REQ-011 wb_rd  in  4;  wb_wrReg  in  1  writeback destination and enable.
REQ-012 pc_wrt_en, IF_wrt_en, DEC_wrt_en, EX_wrt_en, ME_wrt_en  out  1 each  pipeline register enables.
REQ-013 dec_bubble  out  1  DEC register loads a NOP (wrReg=0, wrMem=0) instead of decode outputs.
REQ-014 if_flush  out  1  IF register loads a NOP instruction word.
REQ-015 state  out  2  FSM state; stall_cycles  out  16  stall counter; sb_err  out  1  sticky scoreboard error.

Function
REQ-016 Scoreboard: each of the NUM_REGS entries SHALL hold a 2-bit pending-write count.
REQ-017 raw_hazard SHALL be dec_valid & ((dec_use_rs1 & pend[dec_rs1]!=0) | (dec_use_rs2 & pend[dec_rs2]!=0)).
REQ-018 A write that is in WB in the current cycle SHALL still count as pending; there is no same-cycle write-through.
REQ-019 Issue SHALL equal dec_valid & ~raw_hazard & state==RUN; on issue with dec_wrReg=1, pend[dec_rd] SHALL increment.
REQ-020 When wb_wrReg=1, pend[wb_rd] SHALL decrement.
REQ-021 An increment and a decrement to the same entry in one cycle SHALL leave it unchanged.
REQ-022 An increment at 3 SHALL saturate and set sb_err; a decrement at 0 SHALL hold 0 and set sb_err.
REQ-023 FSM states SHALL be RUN=0, BR_WAIT=1, REDIRECT=2.
REQ-024 RUN with raw_hazard: pc_wrt_en=0, IF_wrt_en=0, DEC_wrt_en=1, dec_bubble=1; EX and ME enables stay 1.
REQ-025 RUN without hazard: all enables are 1 and dec_bubble=0.
REQ-026 Issuing an instruction with dec_is_br=1 SHALL transition RUN->BR_WAIT.
REQ-027 BR_WAIT: pc_wrt_en=0, IF_wrt_en=0, dec_bubble=1 every cycle.
REQ-028 BR_WAIT with ex_br_resolved & ~ex_take_br SHALL transition ->RUN; the held IF instruction then proceeds.
REQ-029 BR_WAIT with ex_br_resolved & ex_take_br SHALL transition ->REDIRECT.
REQ-030 REDIRECT (exactly one cycle): pc_wrt_en=1 loads the target, IF_wrt_en=1, if_flush=1, dec_bubble=1; then ->RUN.
REQ-031 ex_br_resolved in RUN or REDIRECT SHALL be ignored.
REQ-032 stall_cycles SHALL increment, with wrap-around, in every cycle where dec_bubble=1 and reset=0.
REQ-033 All outputs are combinational from state/scoreboard/inputs except stall_cycles, sb_err and state, which are registered.

Reset
REQ-034 On reset=1 at a clk edge: all pend=0, state=RUN, stall_cycles=0, sb_err=0.
REQ-035 Reset SHALL take priority over every simultaneous event, including an in-progress branch wait, which is abandoned.
REQ-036 While reset=1, all *_wrt_en=1 and dec_bubble=1, if_flush=1, so pipeline registers clear to NOPs.

Structure
REQ-037 The shared package SHALL hold the state encodings (RUN, BR_WAIT, REDIRECT), REG_INDEX_BIT_WIDTH, NUM_REGS and the 2-bit pending-count width.
REQ-038 The scoreboard SHALL be one sub-module, reg_scoreboard (inc port, dec port, two read ports, err output); the FSM and enable logic stay in the top.
REQ-039 Target size is 120-400 lines of RTL; there are no memories, and the scoreboard is flops.

Verification
REQ-040 Issue r3 write; next cycle decode reads r3 -> dec_bubble=1, pc_wrt_en=0, until the cycle after wb_rd=3, wb_wrReg=1; stall_cycles=3.
REQ-041 Decode reads r5 with dec_use_rs1=0 while pend[5]=1 -> no stall.
REQ-042 Issue branch; ex_br_resolved=1, ex_take_br=1 two cycles later -> states RUN, BR_WAIT, BR_WAIT, REDIRECT (if_flush=1, pc_wrt_en=1), RUN.
REQ-043 Same with ex_take_br=0 -> BR_WAIT->RUN with no if_flush pulse.
REQ-044 Same-cycle issue to r7 and WB to r7 with pend[7]=1 -> pend[7] stays 1; WB to r9 with pend[9]=0 -> sb_err=1 and stays set.
REQ-045 Assert reset in BR_WAIT with pend[2]=2 -> next cycle state=0, pend all 0, stall_cycles=0.
